mem_rr_sram: RTL and testbench

- N-port word-addressed SRAM model with a round-robin arbiter and a configurable read-latency response pipeline.
- Successor to the single-port req/we/addr/be/wdata SRAM behind the AXI-to-memory bridge in the Ariane test harness.
- Several masters (e.g. multiple axi2mem instances, or a DMA beside the core) share one memory.
- Protocol is OBI-like: req/gnt handshake, then rvalid after a fixed latency.

---
 rtl/mem_rr_sram.sv | 180 ++++++++++++++++++
 tb/tb_mem_rr_sram.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_sram.sv
// rtl/mem_rr_sram.sv - N-port round-robin SRAM with fixed-latency response pipeline
// Optional MEM_RR_STALL_EN: LFSR-driven random grant suppression for handshake stress.
module mem_rr_sram #(
    parameter int unsigned NumPorts    = 2,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned NumWords    = 2**16,
    parameter int unsigned ReadLatency = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumPorts-1:0]             req_i,
    input  logic [NumPorts-1:0]             we_i,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    input  logic [NumPorts*DataWidth/8-1:0] be_i,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i,
    output logic [NumPorts-1:0]             gnt_o,
    output logic [NumPorts-1:0]             rvalid_o,
    output logic [NumPorts*DataWidth-1:0]   rdata_o
);
    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);
    localparam int unsigned IdxW     = $clog2(NumWords);
    localparam int unsigned PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned Last     = ReadLatency - 1;

    typedef logic [PortW-1:0]     port_t;
    typedef logic [DataWidth-1:0] word_t;

    word_t                mem [NumWords];

    port_t                ptr_q, ptr_d;
    logic                 stall;
    logic                 grant_vld;
    port_t                grant_idx;
    logic [NumPorts-1:0]  gnt;

    logic [AddrWidth-1:0] port_addr  [NumPorts];
    logic [NumBytes-1:0]  port_be    [NumPorts];
    word_t                port_wdata [NumPorts];

    logic [AddrWidth-1:0] sel_addr;
    logic [NumBytes-1:0]  sel_be;
    word_t                sel_wdata;
    logic                 sel_we;
    logic [IdxW-1:0]      word_idx;
    logic                 unused_addr;

    logic                 pipe_vld_q  [ReadLatency];
    logic                 pipe_vld_d  [ReadLatency];
    port_t                pipe_port_q [ReadLatency];
    port_t                pipe_port_d [ReadLatency];
    logic                 pipe_we_q   [ReadLatency];
    logic                 pipe_we_d   [ReadLatency];
    word_t                pipe_data_q [ReadLatency];
    word_t                pipe_data_d [ReadLatency];

    word_t                hold_q [NumPorts];
    word_t                hold_d [NumPorts];

`ifdef MEM_RR_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign stall = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            port_addr[p]  = addr_i[p*AddrWidth +: AddrWidth];
            port_be[p]    = be_i[p*NumBytes +: NumBytes];
            port_wdata[p] = wdata_i[p*DataWidth +: DataWidth];
        end
    end

    // Rotating priority search starting at ptr; reset low forces all grants off.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        gnt       = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = (32'(ptr_q) + i) % NumPorts;
            if (!grant_vld && req_i[port_t'(cand)] && rst_ni && !stall) begin
                grant_vld = 1'b1;
                grant_idx = port_t'(cand);
            end
        end
        if (grant_vld) begin
            gnt[grant_idx] = 1'b1;
        end
        ptr_d = grant_vld ? port_t'((32'(grant_idx) + 1) % NumPorts) : ptr_q;
    end

    assign gnt_o       = gnt;
    assign sel_addr    = port_addr[grant_idx];
    assign sel_be      = port_be[grant_idx];
    assign sel_wdata   = port_wdata[grant_idx];
    assign sel_we      = we_i[grant_idx];
    assign word_idx    = sel_addr[OffW +: IdxW];
    assign unused_addr = ^sel_addr;

    always_comb begin
        pipe_vld_d[0]  = grant_vld;
        pipe_port_d[0] = grant_idx;
        pipe_we_d[0]   = sel_we;
        pipe_data_d[0] = mem[word_idx];
        for (int i = 1; i < ReadLatency; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_port_d[i] = pipe_port_q[i-1];
            pipe_we_d[i]   = pipe_we_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    // Final stage drives the addressed port; other ports present their last response.
    always_comb begin
        logic resp;
        resp     = 1'b0;
        rvalid_o = '0;
        rdata_o  = '0;
        for (int p = 0; p < NumPorts; p++) begin
            resp        = pipe_vld_q[Last] && (pipe_port_q[Last] == port_t'(p));
            rvalid_o[p] = resp;
            hold_d[p]   = resp ? (pipe_we_q[Last] ? '0 : pipe_data_q[Last]) : hold_q[p];
            rdata_o[p*DataWidth +: DataWidth] = hold_d[p];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            for (int i = 0; i < ReadLatency; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_port_q[i] <= '0;
                pipe_we_q[i]   <= 1'b0;
                pipe_data_q[i] <= '0;
            end
            for (int p = 0; p < NumPorts; p++) begin
                hold_q[p] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < ReadLatency; i++) begin
                pipe_vld_q[i]  <= pipe_vld_d[i];
                pipe_port_q[i] <= pipe_port_d[i];
                pipe_we_q[i]   <= pipe_we_d[i];
                pipe_data_q[i] <= pipe_data_d[i];
            end
            for (int p = 0; p < NumPorts; p++) begin
                hold_q[p] <= hold_d[p];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant_vld && sel_we) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (sel_be[b]) begin
                    mem[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_rr_sram.sv
// tb/tb_mem_rr_sram.sv - three latency variants of mem_rr_sram driven in lockstep against a reference model
module tb_mem_rr_sram;
    localparam int NP = 4;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int NW = 256;
    localparam int NB = DW / 8;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    req, we;
    logic [NP*AW-1:0] addr;
    logic [NP*NB-1:0] be;
    logic [NP*DW-1:0] wdata;

    logic [NP-1:0]    gnt0, gnt1, gnt2, rv0, rv1, rv2;
    logic [NP*DW-1:0] rd0, rd1, rd2;

    mem_rr_sram #(.NumPorts(NP), .DataWidth(DW), .AddrWidth(AW), .NumWords(NW), .ReadLatency(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt0), .rvalid_o(rv0), .rdata_o(rd0));
    mem_rr_sram #(.NumPorts(NP), .DataWidth(DW), .AddrWidth(AW), .NumWords(NW), .ReadLatency(3)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1));
    mem_rr_sram #(.NumPorts(NP), .DataWidth(DW), .AddrWidth(AW), .NumWords(NW), .ReadLatency(4)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt2), .rvalid_o(rv2), .rdata_o(rd2));

    logic [NP-1:0]    gnt_w [ND];
    logic [NP-1:0]    rv_w  [ND];
    logic [NP*DW-1:0] rd_w  [ND];
    always_comb begin
        gnt_w[0] = gnt0; gnt_w[1] = gnt1; gnt_w[2] = gnt2;
        rv_w[0]  = rv0;  rv_w[1]  = rv1;  rv_w[2]  = rv2;
        rd_w[0]  = rd0;  rd_w[1]  = rd1;  rd_w[2]  = rd2;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ptr_m = 0;
    int last_gnt = -1;
    int snap_cyc = 0;
    int rl_m [ND] = '{1, 3, 4};

    logic [DW-1:0] mem_m  [NW];
    logic [DW-1:0] hold_m [ND][NP];

    typedef struct {
        int            dut;
        int            due;
        int            port;
        logic [DW-1:0] data;
    } resp_t;
    resp_t rq[$];

    logic [NP-1:0] snap_gnt [ND];
    logic [NP-1:0] snap_rv  [ND];
    logic [DW-1:0] snap_rd  [ND][NP];

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = $urandom;
        a[10:3] = 8'($urandom_range(0, 15));
        return a;
    endfunction

    task automatic set_port(int p, logic w, logic [AW-1:0] a, logic [NB-1:0] b, logic [DW-1:0] d);
        we[p] = w;
        addr[p*AW +: AW] = a;
        be[p*NB +: NB] = b;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic model_reset();
        rq.delete();
        ptr_m = 0;
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < NP; p++) hold_m[d][p] = '0;
    endtask

    // One clock: compare all DUT outputs with the model mid-cycle, then commit the model at the edge.
    task automatic cycle();
        int            k;
        int            widx;
        logic [NP-1:0] eg;
        logic [NP-1:0] erv;
        logic [DW-1:0] erd [NP];
        logic [DW-1:0] rdat;
        @(negedge clk);
        k = -1;
        for (int i = 0; i < NP; i++) begin
            if (k < 0 && req[(ptr_m + i) % NP]) k = (ptr_m + i) % NP;
        end
        eg = (k >= 0) ? (4'b0001 << k) : 4'b0000;
        snap_cyc = cyc;
        last_gnt = k;
        for (int d = 0; d < ND; d++) begin
            snap_gnt[d] = gnt_w[d];
            snap_rv[d]  = rv_w[d];
            erv = '0;
            for (int p = 0; p < NP; p++) begin
                erd[p] = hold_m[d][p];
                snap_rd[d][p] = rd_w[d][p*DW +: DW];
            end
            foreach (rq[i]) begin
                if (rq[i].dut == d && rq[i].due == cyc) begin
                    erv[rq[i].port] = 1'b1;
                    erd[rq[i].port] = rq[i].data;
                end
            end
            total++;
            if (gnt_w[d] !== eg) begin
                bad++;
                $display("FAIL gnt dut%0d cyc %0d: got %b want %b", d, cyc, gnt_w[d], eg);
            end
            total++;
            if (rv_w[d] !== erv) begin
                bad++;
                $display("FAIL rvalid dut%0d cyc %0d: got %b want %b", d, cyc, rv_w[d], erv);
            end
            for (int p = 0; p < NP; p++) begin
                total++;
                if (rd_w[d][p*DW +: DW] !== erd[p]) begin
                    bad++;
                    $display("FAIL rdata dut%0d port%0d cyc %0d: got %h want %h",
                             d, p, cyc, rd_w[d][p*DW +: DW], erd[p]);
                end
                hold_m[d][p] = erd[p];
            end
        end
        @(posedge clk);
        if (k >= 0) begin
            widx = int'(addr[k*AW + 3 +: 8]);
            rdat = '0;
            if (we[k]) begin
                for (int b = 0; b < NB; b++)
                    if (be[k*NB + b]) mem_m[widx][b*8 +: 8] = wdata[k*DW + b*8 +: 8];
            end else begin
                rdat = mem_m[widx];
            end
            for (int d = 0; d < ND; d++) rq.push_back('{d, cyc + rl_m[d], k, rdat});
            ptr_m = (k + 1) % NP;
        end
        cyc++;
        for (int i = rq.size() - 1; i >= 0; i--) begin
            if (rq[i].due < cyc) rq.delete(i);
        end
        #1;
    endtask

    task automatic issue(int p, logic w, logic [AW-1:0] a, logic [NB-1:0] b, logic [DW-1:0] d);
        bit done;
        done = 1'b0;
        set_port(p, w, a, b, d);
        req = '0;
        req[p] = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            cycle();
            if (last_gnt == p) done = 1'b1;
        end
        req[p] = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL issue port%0d: granted=%0d want granted=1 within 8 cycles", p, done);
        end
    endtask

    task automatic drain(int n);
        req = '0;
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        req = '1; we = '1; addr = '0; be = '1; wdata = '1;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            total++;
            if (gnt_w[d] !== '0 || rv_w[d] !== '0 || rd_w[d] !== '0) begin
                bad++;
                $display("FAIL in_reset dut%0d: gnt=%b rvalid=%b rdata=%h want all 0", d, gnt_w[d], rv_w[d], rd_w[d]);
            end
        end
        @(posedge clk); #1;
        req = '0;
        rst_n = 1'b1;
        cycle();
        for (int d = 0; d < ND; d++) begin
            total++;
            if (snap_gnt[d] !== '0 || snap_rv[d] !== '0 || snap_rd[d][0] !== '0) begin
                bad++;
                $display("FAIL post_reset dut%0d: gnt=%b rvalid=%b rdata0=%h want 0", d, snap_gnt[d], snap_rv[d], snap_rd[d][0]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] exp_g;
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, rand_addr(), '0, {$urandom, $urandom});
        req = '1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            exp_g = 4'b0001 << (i % NP);
            total++;
            if (snap_gnt[0] !== exp_g || $countones(snap_gnt[0]) != 1) begin
                bad++;
                $display("FAIL rr_order step %0d: got %b want %b", i, snap_gnt[0], exp_g);
            end
        end
        drain(5);
    endtask

    task automatic test_write_read();
        issue(0, 1'b1, 32'h40, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        issue(0, 1'b0, 32'h40, 8'hFF, '0);
        cycle();
        total++;
        if (snap_rv[0][0] !== 1'b1 || snap_rd[0][0] !== 64'hDEADBEEF_CAFEF00D) begin
            bad++;
            $display("FAIL write_read: rvalid=%b rdata=%h want 1 deadbeefcafef00d", snap_rv[0][0], snap_rd[0][0]);
        end
        drain(5);
    endtask

    task automatic test_byte_enable();
        issue(2, 1'b1, 32'h80, 8'hFF, 64'h11111111_11111111);
        issue(2, 1'b1, 32'h80, 8'h0F, 64'hFFFFFFFF_FFFFFFFF);
        issue(2, 1'b0, 32'h80, 8'h00, '0);
        cycle();
        total++;
        if (snap_rv[0][2] !== 1'b1 || snap_rd[0][2] !== 64'h11111111_FFFFFFFF) begin
            bad++;
            $display("FAIL byte_enable: rvalid=%b rdata=%h want 1 11111111ffffffff", snap_rv[0][2], snap_rd[0][2]);
        end
        drain(5);
    endtask

    task automatic test_latency();
        int  t;
        bit  ev;
        issue(1, 1'b1, 32'h100, 8'hFF, 64'd1);
        issue(1, 1'b1, 32'h108, 8'hFF, 64'd2);
        issue(1, 1'b1, 32'h110, 8'hFF, 64'd3);
        t = cyc;
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            set_port(1, 1'b0, 32'h100 + 32'(i * 8), '0, '0);
            cycle();
            total++;
            if (last_gnt != 1 || snap_gnt[1] !== 4'b0010) begin
                bad++;
                $display("FAIL lat_grant %0d: got %b want 0010", i, snap_gnt[1]);
            end
        end
        req = '0;
        for (int j = 0; j < 5; j++) begin
            cycle();
            ev = (snap_cyc >= t + 3 && snap_cyc <= t + 5);
            total++;
            if (snap_rv[1][1] !== ev) begin
                bad++;
                $display("FAIL lat_rvalid t+%0d: got %b want %b", snap_cyc - t, snap_rv[1][1], ev);
            end
            if (ev) begin
                total++;
                if (snap_rd[1][1] !== 64'(snap_cyc - t - 2)) begin
                    bad++;
                    $display("FAIL lat_rdata t+%0d: got %h want %0d", snap_cyc - t, snap_rd[1][1], snap_cyc - t - 2);
                end
            end
        end
        drain(3);
    endtask

    task automatic test_alias();
        logic [DW-1:0] v;
        v = {$urandom, $urandom};
        issue(3, 1'b1, 32'h0, 8'hFF, v);
        issue(3, 1'b0, 32'(NW * 8), 8'h00, '0);
        cycle();
        total++;
        if (snap_rv[0][3] !== 1'b1 || snap_rd[0][3] !== v) begin
            bad++;
            $display("FAIL alias: rvalid=%b rdata=%h want 1 %h", snap_rv[0][3], snap_rd[0][3], v);
        end
        drain(5);
    endtask

    task automatic test_init_words();
        for (int w = 0; w < 16; w++)
            issue(w % NP, 1'b1, 32'(w * 8), 8'hFF, {$urandom, $urandom});
        drain(5);
    endtask

    task automatic test_random(int n);
        bit pend [NP];
        int grants;
        grants = 0;
        for (int p = 0; p < NP; p++) pend[p] = 1'b0;
        for (int c = 0; c < n; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p] = 1'b1;
                    set_port(p, 1'($urandom_range(0, 1)), rand_addr(), NB'($urandom), {$urandom, $urandom});
                end
                req[p] = pend[p];
            end
            cycle();
            if (last_gnt >= 0) begin
                pend[last_gnt] = 1'b0;
                grants++;
            end
        end
        drain(6);
        total++;
        if (grants < n / 2) begin
            bad++;
            $display("FAIL random_throughput: grants=%0d want >= %0d", grants, n / 2);
        end
    endtask

    task automatic test_reset_midflight();
        issue(0, 1'b0, 32'h18, '0, '0);
        issue(0, 1'b0, 32'h20, '0, '0);
        req = '1;
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                total++;
                if (gnt_w[d] !== '0 || rv_w[d] !== '0 || rd_w[d] !== '0) begin
                    bad++;
                    $display("FAIL mid_reset dut%0d: gnt=%b rvalid=%b rdata=%h want all 0", d, gnt_w[d], rv_w[d], rd_w[d]);
                end
            end
            @(posedge clk); #1;
        end
        req = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            for (int d = 0; d < ND; d++) begin
                total++;
                if (snap_rv[d] !== '0) begin
                    bad++;
                    $display("FAIL stale_rvalid dut%0d cyc %0d: got %b want 0000", d, snap_cyc, snap_rv[d]);
                end
            end
        end
        set_port(2, 1'b0, rand_addr(), '0, '0);
        req = 4'b0100;
        cycle();
        for (int d = 0; d < ND; d++) begin
            total++;
            if (snap_gnt[d] !== 4'b0100) begin
                bad++;
                $display("FAIL first_after_reset dut%0d: got %b want 0100", d, snap_gnt[d]);
            end
        end
        drain(6);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_byte_enable();
        test_latency();
        test_alias();
        test_init_words();
        test_random(400);
        test_reset_midflight();
        test_random(200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
